// File: rtl/rw_alu_pkg.sv
// Shared ALU definitions for the RockWave core: datapath width, funct_alu codes
// and the decoded operation classes.
package rw_alu_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] FUNCT_ADD  = 4'b0000;
   localparam logic [3:0] FUNCT_SLL  = 4'b0001;
   localparam logic [3:0] FUNCT_SLT  = 4'b0010;
   localparam logic [3:0] FUNCT_SLTU = 4'b0011;
   localparam logic [3:0] FUNCT_XOR  = 4'b0100;
   localparam logic [3:0] FUNCT_SRL  = 4'b0101;
   localparam logic [3:0] FUNCT_OR   = 4'b0110;
   localparam logic [3:0] FUNCT_AND  = 4'b0111;
   localparam logic [3:0] FUNCT_SUB  = 4'b1000;
   localparam logic [3:0] FUNCT_SRA  = 4'b1101;

   typedef enum logic [1:0] {
      OPC_R     = 2'b00,
      OPC_I     = 2'b01,
      OPC_ADDR  = 2'b10,
      OPC_PCREL = 2'b11
   } opclass_e;

endpackage

// File: rtl/alu_funct_gen.sv
// Maps an instruction's opclass/funct3/funct7b5 to the 4-bit ALU function code.
module alu_funct_gen
   import rw_alu_pkg::*;
(
   input  logic [1:0] opclass,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [3:0] funct
);

   always_comb begin
      // NOTE: default assignment first so every path drives funct and no latch is inferred.
      funct = FUNCT_ADD;
      case (opclass)
         OPC_R:   funct = {funct7b5, funct3};
         // Bit 30 only selects SRAI for immediates; ADDI must never become SUB.
         OPC_I:   funct = {(funct3 == 3'b101) ? funct7b5 : 1'b0, funct3};
         default: funct = FUNCT_ADD;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand slot E feeds the external ALU, result slot R captures its
// output for writeback; both slots use valid/ready handshakes with full back-pressure.
module ex_stage #(
   parameter int XLEN = rw_alu_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            dec_valid,
   output logic            dec_ready,
   input  logic [XLEN-1:0] dec_rs1,
   input  logic [XLEN-1:0] dec_rs2,
   input  logic [XLEN-1:0] dec_imm,
   input  logic [XLEN-1:0] dec_pc,
   input  logic [2:0]      dec_funct3,
   input  logic            dec_funct7b5,
   input  logic [1:0]      dec_opclass,
   input  logic [4:0]      dec_rd,
   output logic [XLEN-1:0] aluin1,
   output logic [XLEN-1:0] aluin2,
   output logic [3:0]      funct_alu,
   input  logic [XLEN-1:0] aluout,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_result,
   output logic [4:0]      ex_rd,
   output logic [XLEN-1:0] ex_rs2
);
   import rw_alu_pkg::*;

   logic            e_valid_q, e_valid_d;
   logic [XLEN-1:0] e_rs1_q, e_rs2_q, e_imm_q, e_pc_q;
   logic [4:0]      e_rd_q;
   logic [1:0]      e_opc_q;
   logic [3:0]      e_funct_q;

   logic            ex_valid_q, ex_valid_d;
   logic [XLEN-1:0] ex_result_q, ex_rs2_q;
   logic [4:0]      ex_rd_q;

   logic [3:0]      dec_funct;
   logic            e_adv, accept, r_load;

   alu_funct_gen u_funct_gen (
      .opclass  (dec_opclass),
      .funct3   (dec_funct3),
      .funct7b5 (dec_funct7b5),
      .funct    (dec_funct)
   );

   assign e_adv     = e_valid_q && (!ex_valid_q || ex_ready);
   assign dec_ready = !e_valid_q || e_adv;
   assign accept    = dec_valid && dec_ready && !flush;
   // Flush wins over an advancing E: the killed instruction never reaches R.
   assign r_load    = e_adv && !flush;

   always_comb begin
      e_valid_d = e_valid_q;
      if (flush)
         e_valid_d = 1'b0;
      else if (accept)
         e_valid_d = 1'b1;
      else if (e_adv)
         e_valid_d = 1'b0;

      ex_valid_d = ex_valid_q;
      if (r_load)
         ex_valid_d = 1'b1;
      else if (ex_ready)
         ex_valid_d = 1'b0;
   end

   always_comb begin
      aluin1    = '0;
      aluin2    = '0;
      funct_alu = '0;
      if (e_valid_q) begin
         aluin1    = (e_opc_q == OPC_PCREL) ? e_pc_q : e_rs1_q;
         aluin2    = (e_opc_q == OPC_R) ? e_rs2_q : e_imm_q;
         funct_alu = e_funct_q;
      end
   end

   // NOTE: datapath registers are reset too, so slot contents are defined (all zero) after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_valid_q <= 1'b0;
         e_rs1_q   <= '0;
         e_rs2_q   <= '0;
         e_imm_q   <= '0;
         e_pc_q    <= '0;
         e_rd_q    <= '0;
         e_opc_q   <= '0;
         e_funct_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         e_valid_q <= e_valid_d;
         if (accept) begin
            e_rs1_q   <= dec_rs1;
            e_rs2_q   <= dec_rs2;
            e_imm_q   <= dec_imm;
            e_pc_q    <= dec_pc;
            e_rd_q    <= dec_rd;
            e_opc_q   <= dec_opclass;
            e_funct_q <= dec_funct;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q  <= 1'b0;
         ex_result_q <= '0;
         ex_rd_q     <= '0;
         ex_rs2_q    <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         if (r_load) begin
            ex_result_q <= aluout;
            ex_rd_q     <= e_rd_q;
            ex_rs2_q    <= e_rs2_q;
         end
      end
   end

   assign ex_valid  = ex_valid_q;
   assign ex_result = ex_result_q;
   assign ex_rd     = ex_rd_q;
   assign ex_rs2    = ex_rs2_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an in-order queue model of the two slots.
module tb_ex_stage;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic            dec_valid = 1'b0;
   logic            dec_ready;
   logic [XLEN-1:0] dec_rs1 = '0, dec_rs2 = '0, dec_imm = '0, dec_pc = '0;
   logic [2:0]      dec_funct3 = '0;
   logic            dec_funct7b5 = 1'b0;
   logic [1:0]      dec_opclass = '0;
   logic [4:0]      dec_rd = '0;
   logic [XLEN-1:0] aluin1, aluin2, aluout;
   logic [3:0]      funct_alu;
   logic            ex_valid;
   logic            ex_ready = 1'b0;
   logic [XLEN-1:0] ex_result, ex_rs2;
   logic [4:0]      ex_rd;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [31:0] rs1, rs2, imm, pc;
      logic [2:0]  f3;
      logic        f7;
      logic [1:0]  opc;
      logic [4:0]  rd;
      bit          in_r;
   } ins_t;

   ins_t mq[$];

   ex_stage #(.XLEN(XLEN)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .dec_valid    (dec_valid),
      .dec_ready    (dec_ready),
      .dec_rs1      (dec_rs1),
      .dec_rs2      (dec_rs2),
      .dec_imm      (dec_imm),
      .dec_pc       (dec_pc),
      .dec_funct3   (dec_funct3),
      .dec_funct7b5 (dec_funct7b5),
      .dec_opclass  (dec_opclass),
      .dec_rd       (dec_rd),
      .aluin1       (aluin1),
      .aluin2       (aluin2),
      .funct_alu    (funct_alu),
      .aluout       (aluout),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .ex_result    (ex_result),
      .ex_rd        (ex_rd),
      .ex_rs2       (ex_rs2)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] f);
      case (f)
         4'b0000: return a + b;
         4'b1000: return a - b;
         4'b0001: return a << b[4:0];
         4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0011: return (a < b) ? 32'd1 : 32'd0;
         4'b0100: return a ^ b;
         4'b0101: return a >> b[4:0];
         4'b1101: return $unsigned($signed(a) >>> b[4:0]);
         4'b0110: return a | b;
         4'b0111: return a & b;
         default: return 32'h0;
      endcase
   endfunction

   // Core-level ALU model closing the loop around the stage.
   assign aluout = alu_f(aluin1, aluin2, funct_alu);

   function automatic logic [3:0] exp_funct(input ins_t i);
      if (i.opc == 2'b00) return {i.f7, i.f3};
      if (i.opc == 2'b01) return (i.f3 == 3'b101) ? {i.f7, i.f3} : {1'b0, i.f3};
      return 4'b0000;
   endfunction

   function automatic logic [31:0] exp_op1(input ins_t i);
      return (i.opc == 2'b11) ? i.pc : i.rs1;
   endfunction

   function automatic logic [31:0] exp_op2(input ins_t i);
      return (i.opc == 2'b00) ? i.rs2 : i.imm;
   endfunction

   function automatic logic [31:0] exp_res(input ins_t i);
      return alu_f(exp_op1(i), exp_op2(i), exp_funct(i));
   endfunction

   function automatic ins_t mk(input logic [1:0] opc, input logic [2:0] f3, input logic f7,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic [4:0] rd);
      ins_t i;
      i.opc = opc; i.f3 = f3; i.f7 = f7; i.rs1 = rs1; i.rs2 = rs2;
      i.imm = imm; i.pc = pc; i.rd = rd; i.in_r = 1'b0;
      return i;
   endfunction

   function automatic ins_t cur_in();
      return mk(dec_opclass, dec_funct3, dec_funct7b5, dec_rs1, dec_rs2, dec_imm, dec_pc, dec_rd);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic set_in(input ins_t i, input logic v);
      dec_rs1 = i.rs1; dec_rs2 = i.rs2; dec_imm = i.imm; dec_pc = i.pc;
      dec_funct3 = i.f3; dec_funct7b5 = i.f7; dec_opclass = i.opc; dec_rd = i.rd;
      dec_valid = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction and hold it until accepted, within a bounded number of cycles.
   task automatic push(input ins_t i);
      bit done;
      done = 1'b0;
      set_in(i, 1'b1);
      for (int n = 0; n < 20 && !done; n++) begin
         done = dec_ready && !flush;
         step();
      end
      dec_valid = 1'b0;
      check("push_accepted", {63'd0, done}, 64'd1);
   endtask

   // Queue model: oldest entry marked in_r sits in the result slot, a trailing entry
   // without in_r sits in the operand slot.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
      end else begin
         bit r_full, e_full, rdy, acc;
         r_full = (mq.size() > 0) && mq[0].in_r;
         e_full = (mq.size() > 0) && !mq[mq.size()-1].in_r;
         rdy    = !e_full || !r_full || ex_ready;
         acc    = dec_valid && rdy && !flush;
         if (r_full && ex_ready) void'(mq.pop_front());
         if (e_full) begin
            if (flush) mq.delete(mq.size()-1);
            else if (!r_full || ex_ready) mq[mq.size()-1].in_r = 1'b1;
         end
         if (acc) mq.push_back(cur_in());
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         bit r_full, e_full;
         ins_t e;
         r_full = (mq.size() > 0) && mq[0].in_r;
         e_full = (mq.size() > 0) && !mq[mq.size()-1].in_r;
         check("m_dec_ready", {63'd0, dec_ready}, {63'd0, (!e_full || !r_full || ex_ready)});
         check("m_ex_valid", {63'd0, ex_valid}, {63'd0, r_full});
         if (r_full) begin
            check("m_ex_result", {32'd0, ex_result}, {32'd0, exp_res(mq[0])});
            check("m_ex_rd", {59'd0, ex_rd}, {59'd0, mq[0].rd});
            check("m_ex_rs2", {32'd0, ex_rs2}, {32'd0, mq[0].rs2});
         end
         if (e_full) begin
            e = mq[mq.size()-1];
            check("m_aluin1", {32'd0, aluin1}, {32'd0, exp_op1(e)});
            check("m_aluin2", {32'd0, aluin2}, {32'd0, exp_op2(e)});
            check("m_funct_alu", {60'd0, funct_alu}, {60'd0, exp_funct(e)});
         end else begin
            check("m_aluin1_idle", {32'd0, aluin1}, 64'd0);
            check("m_aluin2_idle", {32'd0, aluin2}, 64'd0);
            check("m_funct_idle", {60'd0, funct_alu}, 64'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ins_t a, b, c;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_dec_ready", {63'd0, dec_ready}, 64'd1);
      check("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
      check("rst_aluin1", {32'd0, aluin1}, 64'd0);
      check("rst_aluin2", {32'd0, aluin2}, 64'd0);
      check("rst_funct", {60'd0, funct_alu}, 64'd0);

      // Funct mapping, ALU drive and 1-edge latency from E to R.
      ex_ready = 1'b1;
      push(mk(2'b00, 3'b000, 1'b1, 32'd5, 32'd3, 32'd0, 32'd0, 5'd1));
      check("r_sub_funct", {60'd0, funct_alu}, 64'h8);
      check("r_sub_in1", {32'd0, aluin1}, 64'd5);
      check("r_sub_in2", {32'd0, aluin2}, 64'd3);
      push(mk(2'b01, 3'b000, 1'b1, 32'd5, 32'd9, 32'd3, 32'd0, 5'd2));
      check("i_addi_funct", {60'd0, funct_alu}, 64'h0);
      check("r_sub_result", {32'd0, ex_result}, 64'd2);
      push(mk(2'b01, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd3));
      check("i_srai_funct", {60'd0, funct_alu}, 64'hD);
      check("i_addi_result", {32'd0, ex_result}, 64'd8);
      step();
      check("i_srai_result", {32'd0, ex_result}, 64'hF800_0000);
      step();
      check("drain_ex_valid", {63'd0, ex_valid}, 64'd0);

      // Operand muxing for PC-relative and address classes.
      push(mk(2'b11, 3'b111, 1'b1, 32'hDEAD, 32'd0, 32'h20, 32'h100, 5'd4));
      check("pcrel_in1", {32'd0, aluin1}, 64'h100);
      check("pcrel_in2", {32'd0, aluin2}, 64'h20);
      check("pcrel_funct", {60'd0, funct_alu}, 64'h0);
      step();
      check("pcrel_valid", {63'd0, ex_valid}, 64'd1);
      check("pcrel_result", {32'd0, ex_result}, 64'h120);
      push(mk(2'b10, 3'b010, 1'b0, 32'h1000, 32'h55, 32'hFFFF_FFFC, 32'h4444, 5'd5));
      step();
      check("addr_result", {32'd0, ex_result}, 64'hFFC);
      check("addr_rs2", {32'd0, ex_rs2}, 64'h55);
      check("addr_rd", {59'd0, ex_rd}, 64'd5);
      step();

      // Back-pressure: two accepted, the third waits until writeback releases.
      ex_ready = 1'b0;
      a = mk(2'b00, 3'b100, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 5'd10);
      b = mk(2'b01, 3'b110, 1'b0, 32'h1, 32'd0, 32'h10, 32'd0, 5'd11);
      c = mk(2'b00, 3'b111, 1'b0, 32'hFF, 32'h0F, 32'd0, 32'd0, 5'd12);
      push(a);
      push(b);
      set_in(c, 1'b1);
      for (int k = 0; k < 3; k++) begin
         check("bp_dec_ready", {63'd0, dec_ready}, 64'd0);
         check("bp_hold_result", {32'd0, ex_result}, 64'hFF00);
         check("bp_hold_rd", {59'd0, ex_rd}, 64'd10);
         step();
      end
      ex_ready = 1'b1;
      #1 check("bp_ready_comb", {63'd0, dec_ready}, 64'd1);
      step();
      dec_valid = 1'b0;
      check("bp_second", {32'd0, ex_result}, 64'h11);
      step();
      check("bp_third", {32'd0, ex_result}, 64'hF);
      step();
      check("bp_empty", {63'd0, ex_valid}, 64'd0);

      // Flush with E full and a new instruction offered.
      ex_ready = 1'b0;
      push(mk(2'b00, 3'b001, 1'b0, 32'd1, 32'd4, 32'd0, 32'd0, 5'd7));
      push(mk(2'b00, 3'b000, 1'b0, 32'd2, 32'd2, 32'd0, 32'd0, 5'd8));
      set_in(mk(2'b01, 3'b000, 1'b0, 32'd9, 32'd0, 32'd9, 32'd0, 5'd9), 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      dec_valid = 1'b0;
      check("fl_aluin1", {32'd0, aluin1}, 64'd0);
      check("fl_dec_ready", {63'd0, dec_ready}, 64'd1);
      check("fl_r_valid", {63'd0, ex_valid}, 64'd1);
      check("fl_r_rd", {59'd0, ex_rd}, 64'd7);
      check("fl_r_result", {32'd0, ex_result}, 64'h10);
      ex_ready = 1'b1;
      step();
      check("fl_nothing_left", {63'd0, ex_valid}, 64'd0);

      // Asynchronous reset between edges with both slots full.
      ex_ready = 1'b0;
      push(mk(2'b00, 3'b000, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 5'd13));
      push(mk(2'b00, 3'b000, 1'b0, 32'd5, 32'd6, 32'd0, 32'd0, 5'd14));
      check("ar_pre_valid", {63'd0, ex_valid}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_ex_valid", {63'd0, ex_valid}, 64'd0);
      check("ar_dec_ready", {63'd0, dec_ready}, 64'd1);
      check("ar_aluin1", {32'd0, aluin1}, 64'd0);
      check("ar_result", {32'd0, ex_result}, 64'd0);
      step();
      step();
      rst_n = 1'b1;

      // Randomized traffic against the queue model.
      for (int k = 0; k < 3000; k++) begin
         ins_t r;
         r = mk(2'($urandom_range(0, 3)), 3'($urandom), 1'($urandom), $urandom, $urandom,
                $urandom, $urandom, 5'($urandom));
         set_in(r, ($urandom_range(0, 99) < 70));
         ex_ready = ($urandom_range(0, 99) < 60);
         flush    = ($urandom_range(0, 99) < 8);
         step();
      end
      dec_valid = 1'b0;
      flush = 1'b0;
      ex_ready = 1'b1;
      repeat (4) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
